// File: rtl/alu_op_dispatch_if.sv
// ---------------------------------------------------------------------------
// alu_op_dispatch_if
//  Bundles the request, unit-side and response signals of the ALU op
//  dispatcher.
//  slave  : the dispatcher view. It takes requests, drives the units and
//           produces responses.
//  master : the environment view. This covers the control path and the ALU
//           units together.
// Signals
//  req_valid / req_ready          request handshake
//  req_select [3:0]               sparse ALU select code
//  req_a / req_b [DATA_W]         operands
//  unit_start [8:0]               one-hot start pulse, bit k = unit k
//  unit_a / unit_b [DATA_W]       operands latched for the units
//  unit_done [8:0]                per-unit completion strobe
//  rsp_valid / rsp_ready          response handshake
//  rsp_unit [3:0]                 unit index 0..8, 4'hF for illegal code
//  rsp_err [1:0]                  00 ok, 01 illegal code, 10 timeout
//  busy                           dispatcher not idle
// ---------------------------------------------------------------------------
interface alu_op_dispatch_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_select;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [8:0]        unit_start;
    logic [DATA_W-1:0] unit_a;
    logic [DATA_W-1:0] unit_b;
    logic [8:0]        unit_done;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [3:0]        rsp_unit;
    logic [1:0]        rsp_err;
    logic              busy;

    modport slave (
        input  req_valid, req_select, req_a, req_b, unit_done, rsp_ready,
        output req_ready, unit_start, unit_a, unit_b, rsp_valid, rsp_unit,
               rsp_err, busy
    );

    modport master (
        output req_valid, req_select, req_a, req_b, unit_done, rsp_ready,
        input  req_ready, unit_start, unit_a, unit_b, rsp_valid, rsp_unit,
               rsp_err, busy
    );
endinterface

// File: rtl/alu_op_dispatch.sv
// ---------------------------------------------------------------------------
// alu_op_dispatch
//  This is the issue-side counterpart of the ALU result mux. The block
//  accepts one op request, which carries a sparse 4-bit select code and two
//  operands. It decodes the code to one of 9 functional units and pulses
//  that unit's start for one cycle while driving the latched operands. It
//  then waits for that unit's done strobe, or gives up after TIMEOUT cycles.
//  Finally it returns a response that carries the unit index and a status.
//  Only one op is in flight at a time.
// Parameters
//  DATA_W   operand width
//  TIMEOUT  WAIT cycles without done before a timeout response (>= 1)
// Ports
//  clk      system clock, rising edge
//  rst_n    asynchronous active-low reset
//  bus      alu_op_dispatch_if.slave. It carries the request, unit and
//           response signals.
// Every output comes straight from a flop.
// ---------------------------------------------------------------------------
module alu_op_dispatch #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_op_dispatch_if.slave   bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [8:0]        unit_mask;   // one-hot copy of the selected unit
    logic [8:0]        start_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [3:0]        rsp_unit_q;
    logic [1:0]        rsp_err_q;
    logic              busy_q;

    // Decode of the incoming select code.
    logic              dec_legal;
    logic [3:0]        dec_idx;
    logic [8:0]        dec_onehot;
    logic              done_hit;

    // NOTE: every signal in a combinational block gets a default first.
    // Without it, a path that does not assign the signal infers a latch.
    always_comb begin
        dec_legal = 1'b1;
        dec_idx   = 4'd0;
        case (bus.req_select)
            4'b0000: dec_idx = 4'd0;
            4'b0001: dec_idx = 4'd1;
            4'b0010: dec_idx = 4'd2;
            4'b0101: dec_idx = 4'd3;
            4'b0110: dec_idx = 4'd4;
            4'b0111: dec_idx = 4'd5;
            4'b1000: dec_idx = 4'd6;
            4'b1001: dec_idx = 4'd7;
            4'b1011: dec_idx = 4'd8;
            default: begin
                dec_legal = 1'b0;
                dec_idx   = 4'hF;
            end
        endcase
        dec_onehot = dec_legal ? (9'b1 << dec_idx) : 9'b0;
    end

    // Only the done strobe of the selected unit counts.
    assign done_hit = |(bus.unit_done & unit_mask);

    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then sees the values from before the edge, and there is no ordering
    // race between blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            unit_mask   <= '0;
            start_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_unit_q  <= 4'd0;
            rsp_err_q   <= ERR_OK;
            busy_q      <= 1'b0;
        end else begin
            // The start pulse lasts exactly the single ISSUE cycle.
            start_q <= '0;

            case (state)
                S_IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        a_q         <= bus.req_a;
                        b_q         <= bus.req_b;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        rsp_unit_q  <= dec_idx;
                        if (dec_legal) begin
                            state     <= S_ISSUE;
                            start_q   <= dec_onehot;
                            unit_mask <= dec_onehot;
                        end else begin
                            // An illegal code skips the units entirely.
                            state       <= S_RESP;
                            unit_mask   <= '0;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= ERR_ILLEGAL;
                        end
                    end else begin
                        // This asserts one clock after reset release.
                        req_ready_q <= 1'b1;
                    end
                end

                S_ISSUE: begin
                    // The unit cannot be done yet, so done is not sampled
                    // here.
                    state    <= S_WAIT;
                    wait_cnt <= '0;
                end

                S_WAIT: begin
                    if (done_hit) begin
                        // A done on the expiry cycle still wins.
                        state       <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= ERR_OK;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state       <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= ERR_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                S_RESP: begin
                    // A late done from the unit is ignored here. The next
                    // request is taken no earlier than the cycle after the
                    // handshake.
                    if (bus.rsp_ready) begin
                        state       <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end

                default: begin
                    state       <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.unit_start = start_q;
    assign bus.unit_a     = a_q;
    assign bus.unit_b     = b_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_unit   = rsp_unit_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_alu_op_dispatch.sv
// ---------------------------------------------------------------------------
// tb_alu_op_dispatch
//  This is the directed bench for alu_op_dispatch. The stimulus pushes the
//  hand-computed expected response into a queue. A separate monitor pops
//  that queue on every response handshake and compares it with the DUT.
//  Cycle-level checks cover the start pulse, the operands, the timing and
//  reset.
// ---------------------------------------------------------------------------
module tb_alu_op_dispatch;

    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic [3:0] unit;
        logic [1:0] err;
    } rsp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    rsp_t exp_q[$];

    alu_op_dispatch_if #(.DATA_W(DATA_W)) dut_if ();

    alu_op_dispatch #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dut_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Move to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor. It runs on the falling edge, away from the active
    // edge.
    always @(negedge clk) begin
        if (rst_n && dut_if.rsp_valid && dut_if.rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got unit 0x%0h err 0x%0h expected no response",
                         dut_if.rsp_unit, dut_if.rsp_err);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_unit", 32'(dut_if.rsp_unit), 32'(e.unit));
                check("rsp_err",  32'(dut_if.rsp_err),  32'(e.err));
            end
        end
    end

    // Issues a legal op from IDLE and completes it, with done on the first
    // WAIT cycle.
    task automatic legal_op(input logic [3:0] sel, input logic [31:0] a,
                            input logic [31:0] b, input logic [3:0] unit,
                            input logic [8:0] onehot);
        check("req_ready_idle", 32'(dut_if.req_ready), 32'd1);
        dut_if.req_valid  = 1'b1;
        dut_if.req_select = sel;
        dut_if.req_a      = a;
        dut_if.req_b      = b;
        exp_q.push_back('{unit: unit, err: 2'b00});
        step();                                   // N+1: ISSUE
        dut_if.req_valid = 1'b0;
        check("issue_start",  32'(dut_if.unit_start), 32'(onehot));
        check("issue_unit_a", dut_if.unit_a, a);
        check("issue_unit_b", dut_if.unit_b, b);
        check("issue_busy",   32'(dut_if.busy), 32'd1);
        check("issue_ready",  32'(dut_if.req_ready), 32'd0);
        step();                                   // N+2: WAIT
        check("wait_start", 32'(dut_if.unit_start), 32'd0);
        check("wait_rsp",   32'(dut_if.rsp_valid), 32'd0);
        dut_if.unit_done = onehot;
        step();                                   // N+3: RESP
        dut_if.unit_done = '0;
        check("rsp_latency", 32'(dut_if.rsp_valid), 32'd1);
        step();                                   // N+4: back in IDLE
        check("post_rsp_valid", 32'(dut_if.rsp_valid), 32'd0);
        check("post_rsp_ready", 32'(dut_if.req_ready), 32'd1);
        check("post_rsp_busy",  32'(dut_if.busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        rst_n             = 1'b0;
        dut_if.req_valid  = 1'b0;
        dut_if.req_select = 4'd0;
        dut_if.req_a      = '0;
        dut_if.req_b      = '0;
        dut_if.unit_done  = '0;
        dut_if.rsp_ready  = 1'b1;

        // ---- Reset state ----
        #2;
        check("rst_ready",     32'(dut_if.req_ready), 32'd0);
        check("rst_start",     32'(dut_if.unit_start), 32'd0);
        check("rst_rsp_valid", 32'(dut_if.rsp_valid), 32'd0);
        check("rst_busy",      32'(dut_if.busy), 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("rel_ready_before_clk", 32'(dut_if.req_ready), 32'd0);
        step();
        check("rel_ready_after_clk", 32'(dut_if.req_ready), 32'd1);

        // ---- 1. Legal op: 0101 -> unit 3 ----
        legal_op(4'b0101, 32'd5, 32'd7, 4'd3, 9'h008);

        // ---- 2. Illegal code 0011 ----
        dut_if.req_valid  = 1'b1;
        dut_if.req_select = 4'b0011;
        exp_q.push_back('{unit: 4'hF, err: 2'b01});
        step();                                   // N+1: RESP
        dut_if.req_valid = 1'b0;
        check("ill_start", 32'(dut_if.unit_start), 32'd0);
        check("ill_rsp",   32'(dut_if.rsp_valid), 32'd1);
        step();
        check("ill_post_valid", 32'(dut_if.rsp_valid), 32'd0);
        check("ill_post_ready", 32'(dut_if.req_ready), 32'd1);

        // ---- 3. Timeout on 1011 -> unit 8, with a late done ignored ----
        dut_if.rsp_ready  = 1'b0;
        dut_if.req_valid  = 1'b1;
        dut_if.req_select = 4'b1011;
        dut_if.req_a      = 32'hDEAD_BEEF;
        dut_if.req_b      = 32'h0000_0001;
        exp_q.push_back('{unit: 4'd8, err: 2'b10});
        step();                                   // N+1: ISSUE
        dut_if.req_valid = 1'b0;
        check("to_start", 32'(dut_if.unit_start), 32'h100);
        for (int i = 0; i < TIMEOUT; i++) begin   // N+2 .. N+17: WAIT
            step();
            if (dut_if.rsp_valid !== 1'b0) begin
                check("to_early_rsp", 32'(dut_if.rsp_valid), 32'd0);
            end
        end
        step();                                   // N+18: RESP
        check("to_rsp_valid", 32'(dut_if.rsp_valid), 32'd1);
        check("to_rsp_unit",  32'(dut_if.rsp_unit), 32'd8);
        check("to_rsp_err",   32'(dut_if.rsp_err), 32'd2);
        dut_if.unit_done = 9'h100;                // late done
        step();
        dut_if.unit_done = '0;
        check("to_late_err",  32'(dut_if.rsp_err), 32'd2);
        check("to_late_unit", 32'(dut_if.rsp_unit), 32'd8);
        dut_if.rsp_ready = 1'b1;
        step();
        check("to_post_valid", 32'(dut_if.rsp_valid), 32'd0);

        // ---- 4. Backpressure: rsp_ready low for 5 cycles ----
        dut_if.rsp_ready  = 1'b0;
        dut_if.req_valid  = 1'b1;
        dut_if.req_select = 4'b0001;
        dut_if.req_a      = 32'd11;
        dut_if.req_b      = 32'd22;
        exp_q.push_back('{unit: 4'd1, err: 2'b00});
        step();                                   // ISSUE
        dut_if.req_select = 4'b0010;              // keep a new request pending
        dut_if.req_a      = 32'd33;
        dut_if.req_b      = 32'd44;
        step();                                   // WAIT
        dut_if.unit_done = 9'h002;
        step();                                   // RESP
        dut_if.unit_done = '0;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(dut_if.rsp_valid), 32'd1);
            check("bp_unit",  32'(dut_if.rsp_unit), 32'd1);
            check("bp_err",   32'(dut_if.rsp_err), 32'd0);
            check("bp_ready", 32'(dut_if.req_ready), 32'd0);
            check("bp_a",     dut_if.unit_a, 32'd11);
            step();
        end
        dut_if.rsp_ready = 1'b1;                  // handshake cycle M
        check("bp_hs_ready", 32'(dut_if.req_ready), 32'd0);
        step();                                   // M+1: IDLE, accepts
        check("bp_m1_valid", 32'(dut_if.rsp_valid), 32'd0);
        check("bp_m1_ready", 32'(dut_if.req_ready), 32'd1);
        exp_q.push_back('{unit: 4'd2, err: 2'b00});
        step();                                   // M+2: ISSUE
        dut_if.req_valid = 1'b0;
        check("bp_new_start", 32'(dut_if.unit_start), 32'h004);
        check("bp_new_a",     dut_if.unit_a, 32'd33);
        step();                                   // M+3: WAIT
        dut_if.unit_done = 9'h004;
        step();                                   // M+4: RESP
        dut_if.unit_done = '0;
        check("bp_new_rsp", 32'(dut_if.rsp_valid), 32'd1);
        step();

        // ---- 5. A done from the wrong unit is ignored ----
        dut_if.req_valid  = 1'b1;
        dut_if.req_select = 4'b0000;
        exp_q.push_back('{unit: 4'd0, err: 2'b00});
        step();                                   // ISSUE
        dut_if.req_valid = 1'b0;
        check("wu_start", 32'(dut_if.unit_start), 32'h001);
        step();                                   // WAIT
        dut_if.unit_done = 9'h002;
        step();
        dut_if.unit_done = '0;
        check("wu_no_rsp1", 32'(dut_if.rsp_valid), 32'd0);
        step();
        check("wu_no_rsp2", 32'(dut_if.rsp_valid), 32'd0);
        dut_if.unit_done = 9'h001;
        step();
        dut_if.unit_done = '0;
        check("wu_rsp", 32'(dut_if.rsp_valid), 32'd1);
        step();

        // ---- 6. Reset while in WAIT ----
        dut_if.req_valid  = 1'b1;
        dut_if.req_select = 4'b0110;
        dut_if.req_a      = 32'h1234;
        dut_if.req_b      = 32'h5678;
        step();                                   // ISSUE
        dut_if.req_valid = 1'b0;
        check("rw_start", 32'(dut_if.unit_start), 32'h010);
        step();                                   // WAIT
        rst_n = 1'b0;
        #1;
        check("rw_start0",  32'(dut_if.unit_start), 32'd0);
        check("rw_a0",      dut_if.unit_a, 32'd0);
        check("rw_b0",      dut_if.unit_b, 32'd0);
        check("rw_valid0",  32'(dut_if.rsp_valid), 32'd0);
        check("rw_unit0",   32'(dut_if.rsp_unit), 32'd0);
        check("rw_err0",    32'(dut_if.rsp_err), 32'd0);
        check("rw_busy0",   32'(dut_if.busy), 32'd0);
        check("rw_ready0",  32'(dut_if.req_ready), 32'd0);
        step();
        step();
        check("rw_hold_valid", 32'(dut_if.rsp_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rw_rel_ready", 32'(dut_if.req_ready), 32'd0);
        step();
        check("rw_idle_ready", 32'(dut_if.req_ready), 32'd1);
        check("rw_idle_busy",  32'(dut_if.busy), 32'd0);
        legal_op(4'b1001, 32'hA5A5_0001, 32'h0F0F_0002, 4'd7, 9'h080);

        step();
        step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
